conv_job_sequencer: RTL and testbench

Sequences convolution jobs onto the single-engine XNOR convolution accelerator. A host pushes jobs (input-SRAM base, output-SRAM base, weight address, tag) into a small FIFO. The sequencer launches one job at a time with a one-cycle run pulse and relocates the accelerator's zero-based SRAM/WMEM addresses by the job's bases. It reports completion, cycle count and start-failure per job through a valid/ready done port.

---
 rtl/conv_job_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_conv_job_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer
//   Queues convolution jobs for a single XNOR convolution engine and runs
//   them one at a time. A job is launched with a one-cycle run pulse. While
//   it is active, the engine's zero-based SRAM/WMEM addresses are relocated
//   by that job's base addresses. Completion is reported on a valid/ready
//   port that carries the tag, a start-failure flag and a saturating count
//   of cycles from launch to busy fall.
//
// Ports
//   clk, reset_b                        clock, async active-low reset
//   job_valid/job_ready                 job push handshake
//   job_in_base/out_base/w_base, job_id per-job bases and tag
//   done_valid/done_ready               completion handshake
//   done_id, done_err, done_cycles      completion report (held until taken)
//   acc_run, acc_busy                   engine launch pulse / busy status
//   acc_rd/wr/w_addr, acc_we            engine-side addresses and write enable
//   sram_rd/wr_addr, wmem_rd_addr       relocated addresses
//   sram_we                             write enable, gated to active states
//   idle                                FIFO empty and sequencer idle
//   jobs_done                           completed-job counter (wraps)
module conv_job_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 4,
    parameter int ID_W     = 4,
    parameter int START_TO = 8
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_in_base,
    input  logic [ADDR_W-1:0] job_out_base,
    input  logic [ADDR_W-1:0] job_w_base,
    input  logic [ID_W-1:0]   job_id,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [ID_W-1:0]   done_id,
    output logic              done_err,
    output logic [15:0]       done_cycles,
    output logic              acc_run,
    input  logic              acc_busy,
    input  logic [ADDR_W-1:0] acc_rd_addr,
    input  logic [ADDR_W-1:0] acc_wr_addr,
    input  logic [ADDR_W-1:0] acc_w_addr,
    input  logic              acc_we,
    output logic [ADDR_W-1:0] sram_rd_addr,
    output logic [ADDR_W-1:0] sram_wr_addr,
    output logic [ADDR_W-1:0] wmem_rd_addr,
    output logic              sram_we,
    output logic              idle,
    output logic [15:0]       jobs_done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TO_W  = $clog2(START_TO + 1);

    // One-hot so every status output decodes from a single state flop.
    typedef enum logic [4:0] {
        S_IDLE      = 5'b00001,
        S_LAUNCH    = 5'b00010,
        S_WAIT_BUSY = 5'b00100,
        S_RUN       = 5'b01000,
        S_REPORT    = 5'b10000
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] fifo_in  [DEPTH];
    logic [ADDR_W-1:0] fifo_out [DEPTH];
    logic [ADDR_W-1:0] fifo_w   [DEPTH];
    logic [ID_W-1:0]   fifo_id  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic [ADDR_W-1:0] act_in_base;
    logic [ADDR_W-1:0] act_out_base;
    logic [ADDR_W-1:0] act_w_base;
    logic [ID_W-1:0]   act_id;
    logic [TO_W-1:0]   wait_cnt;
    logic [15:0]       cycles;
    logic [15:0]       cycles_inc;

    assign full      = (count == (PTR_W + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign job_ready = ~full;
    assign push      = job_valid & ~full;
    assign pop       = (state == S_IDLE) & ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_in[wr_ptr]  <= job_in_base;
            fifo_out[wr_ptr] <= job_out_base;
            fifo_w[wr_ptr]   <= job_w_base;
            fifo_id[wr_ptr]  <= job_id;
        end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap at DEPTH naturally.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign cycles_inc = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state        <= S_IDLE;
            act_in_base  <= '0;
            act_out_base <= '0;
            act_w_base   <= '0;
            act_id       <= '0;
            done_err     <= 1'b0;
            wait_cnt     <= '0;
            cycles       <= '0;
            jobs_done    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        state        <= S_LAUNCH;
                        act_in_base  <= fifo_in[rd_ptr];
                        act_out_base <= fifo_out[rd_ptr];
                        act_w_base   <= fifo_w[rd_ptr];
                        act_id       <= fifo_id[rd_ptr];
                        done_err     <= 1'b0;
                        wait_cnt     <= '0;
                        cycles       <= '0;
                    end
                end
                S_LAUNCH: begin
                    state  <= S_WAIT_BUSY;
                    cycles <= cycles_inc;
                end
                S_WAIT_BUSY: begin
                    cycles <= cycles_inc;
                    if (acc_busy) begin
                        state <= S_RUN;
                    end else if (wait_cnt == TO_W'(START_TO - 1)) begin
                        state    <= S_REPORT;
                        done_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    cycles <= cycles_inc;
                    if (!acc_busy) state <= S_REPORT;
                end
                S_REPORT: begin
                    if (done_ready) begin
                        state     <= S_IDLE;
                        jobs_done <= jobs_done + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign acc_run     = (state == S_LAUNCH);
    assign done_valid  = (state == S_REPORT);
    assign idle        = (state == S_IDLE) & empty;
    assign done_id     = act_id;
    assign done_cycles = cycles;

    assign sram_rd_addr = acc_rd_addr + act_in_base;
    assign sram_wr_addr = acc_wr_addr + act_out_base;
    assign wmem_rd_addr = acc_w_addr + act_w_base;
    assign sram_we      = acc_we & ((state == S_WAIT_BUSY) | (state == S_RUN));

endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb_conv_job_sequencer
//   Directed bench for conv_job_sequencer. A small accelerator model raises
//   busy one edge after it samples acc_run and holds it for busy_len cycles.
//   A busy_len of 0 means busy is never raised. Inputs are driven on the
//   falling edge, and outputs are sampled shortly after that edge.
module tb_conv_job_sequencer;
    logic        clk;
    logic        reset_b;
    logic        job_valid;
    logic        job_ready;
    logic [11:0] job_in_base;
    logic [11:0] job_out_base;
    logic [11:0] job_w_base;
    logic [3:0]  job_id;
    logic        done_valid;
    logic        done_ready;
    logic [3:0]  done_id;
    logic        done_err;
    logic [15:0] done_cycles;
    logic        acc_run;
    logic        acc_busy;
    logic [11:0] acc_rd_addr;
    logic [11:0] acc_wr_addr;
    logic [11:0] acc_w_addr;
    logic        acc_we;
    logic [11:0] sram_rd_addr;
    logic [11:0] sram_wr_addr;
    logic [11:0] wmem_rd_addr;
    logic        sram_we;
    logic        idle;
    logic [15:0] jobs_done;

    conv_job_sequencer #(.ADDR_W(12), .DEPTH(4), .ID_W(4), .START_TO(8)) dut (
        .clk(clk), .reset_b(reset_b),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_in_base(job_in_base), .job_out_base(job_out_base),
        .job_w_base(job_w_base), .job_id(job_id),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_id(done_id), .done_err(done_err), .done_cycles(done_cycles),
        .acc_run(acc_run), .acc_busy(acc_busy),
        .acc_rd_addr(acc_rd_addr), .acc_wr_addr(acc_wr_addr),
        .acc_w_addr(acc_w_addr), .acc_we(acc_we),
        .sram_rd_addr(sram_rd_addr), .sram_wr_addr(sram_wr_addr),
        .wmem_rd_addr(wmem_rd_addr), .sram_we(sram_we),
        .idle(idle), .jobs_done(jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned busy_len;
    int unsigned busy_cnt;
    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            acc_busy <= 1'b0;
            busy_cnt <= 0;
        end else if (acc_run && busy_len != 0) begin
            acc_busy <= 1'b1;
            busy_cnt <= busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) acc_busy <= 1'b0;
        end
    end

    logic       mon_en;
    logic [3:0] done_q[$];
    always @(negedge clk) begin
        #2;
        if (mon_en && done_valid && done_ready) done_q.push_back(done_id);
    end

    int total;
    int bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [11:0] ib, input logic [11:0] ob,
                        input logic [11:0] wb, input logic [3:0] id);
        job_in_base = ib; job_out_base = ob; job_w_base = wb; job_id = id;
        job_valid = 1'b1;
        for (int i = 0; i < 300 && !job_ready; i++) @(negedge clk);
        chk("push_accept", job_ready, 1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done_valid, 1);
    endtask

    typedef struct {
        logic [11:0] rd, wr, w;
        logic        we;
        logic [11:0] e_rd, e_wr, e_w;
        logic        e_we;
    } vec_t;
    vec_t vt[6];

    initial begin
        total = 0; bad = 0;
        reset_b = 1'b0; job_valid = 1'b0; done_ready = 1'b0;
        job_in_base = '0; job_out_base = '0; job_w_base = '0; job_id = '0;
        acc_rd_addr = '0; acc_wr_addr = '0; acc_w_addr = '0; acc_we = 1'b0;
        busy_len = 0; mon_en = 1'b0;

        // Relocation table, applied while job 3 (bases 0x100/0x200/0x010) runs.
        vt[0] = '{12'h005, 12'h000, 12'h001, 1'b1, 12'h105, 12'h200, 12'h011, 1'b1};
        vt[1] = '{12'h000, 12'h007, 12'h000, 1'b0, 12'h100, 12'h207, 12'h010, 1'b0};
        vt[2] = '{12'hEFF, 12'hDFF, 12'hFEF, 1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1};
        vt[3] = '{12'hF00, 12'hE00, 12'hFF0, 1'b0, 12'h000, 12'h000, 12'h000, 1'b0};
        vt[4] = '{12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 12'h0FF, 12'h1FF, 12'h00F, 1'b1};
        vt[5] = '{12'h123, 12'h456, 12'h789, 1'b1, 12'h223, 12'h656, 12'h799, 1'b1};

        // Reset values.
        @(negedge clk);
        acc_we = 1'b1; acc_rd_addr = 12'h005; #1;
        chk("rst_job_ready", job_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_done_err", done_err, 0);
        chk("rst_done_cycles", done_cycles, 0);
        chk("rst_acc_run", acc_run, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_rd_addr", sram_rd_addr, 12'h005);
        acc_we = 1'b0; acc_rd_addr = '0;
        @(negedge clk); reset_b = 1'b1;
        @(negedge clk);

        // Single job: accept at E0, LAUNCH E1..E2, busy E2..E22, report at E23.
        busy_len = 20;
        push(12'h100, 12'h200, 12'h010, 4'd3);
        chk("single_run_early", acc_run, 0);
        chk("single_idle", idle, 0);
        @(negedge clk); chk("single_run_pulse", acc_run, 1);
        @(negedge clk); chk("single_run_end", acc_run, 0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            acc_rd_addr = vt[i].rd; acc_wr_addr = vt[i].wr;
            acc_w_addr = vt[i].w; acc_we = vt[i].we;
            #1;
            chk("vec_rd", sram_rd_addr, vt[i].e_rd);
            chk("vec_wr", sram_wr_addr, vt[i].e_wr);
            chk("vec_w", wmem_rd_addr, vt[i].e_w);
            chk("vec_we", sram_we, vt[i].e_we);
            chk("vec_no_run", acc_run, 0);
            @(negedge clk);
        end
        acc_rd_addr = '0; acc_wr_addr = '0; acc_w_addr = '0; acc_we = 1'b0;
        wait_done();
        chk("single_id", done_id, 3);
        chk("single_err", done_err, 0);
        chk("single_cycles", done_cycles, 22);
        done_ready = 1'b1;
        @(negedge clk); done_ready = 1'b0;
        chk("single_hs_valid", done_valid, 0);
        chk("single_jobs", jobs_done, 1);
        chk("single_idle_after", idle, 1);

        // Start failure: 8 WAIT_BUSY cycles, then REPORT with err.
        busy_len = 0;
        push(12'h000, 12'h000, 12'h000, 4'd7);
        push(12'h000, 12'h000, 12'h000, 4'd8);
        chk("sf_run", acc_run, 1);
        repeat (8) @(negedge clk);
        chk("sf_still_waiting", done_valid, 0);
        @(negedge clk);
        chk("sf_report", done_valid, 1);
        chk("sf_err", done_err, 1);
        chk("sf_id", done_id, 7);
        chk("sf_cycles", done_cycles, 9);
        busy_len = 4;
        done_ready = 1'b1;
        @(negedge clk); done_ready = 1'b0;
        chk("sf_bubble_run", acc_run, 0);
        chk("sf_bubble_valid", done_valid, 0);
        chk("sf_jobs", jobs_done, 2);
        @(negedge clk); chk("sf_next_launch", acc_run, 1);

        // Backpressure on job 8's report while job 9 is pushed.
        wait_done();
        chk("j8_id", done_id, 8);
        chk("j8_err", done_err, 0);
        chk("j8_cycles", done_cycles, 6);
        job_in_base = 12'h000; job_out_base = 12'hFFE; job_w_base = 12'h000;
        job_id = 4'd9; job_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            job_valid = 1'b0;
            chk("bp_valid", done_valid, 1);
            chk("bp_id", done_id, 8);
            chk("bp_err", done_err, 0);
            chk("bp_cycles", done_cycles, 6);
            chk("bp_no_run", acc_run, 0);
            chk("bp_jobs", jobs_done, 2);
        end
        done_ready = 1'b1; #1;
        chk("bp_jobs_pre_hs", jobs_done, 2);
        @(negedge clk); done_ready = 1'b0;
        chk("bp_jobs_hs", jobs_done, 3);
        chk("bp_bubble_run", acc_run, 0);
        chk("bp_queued_idle", idle, 0);
        @(negedge clk); chk("j9_launch", acc_run, 1);

        // Address wrap on out_base 0xFFE, then write gating in IDLE.
        @(negedge clk);
        acc_wr_addr = 12'h003; acc_we = 1'b1; #1;
        chk("wrap_wr_addr", sram_wr_addr, 12'h001);
        chk("wrap_we_active", sram_we, 1);
        wait_done();
        chk("j9_id", done_id, 9);
        chk("j9_cycles", done_cycles, 6);
        done_ready = 1'b1;
        @(negedge clk); done_ready = 1'b0; #1;
        chk("j9_jobs", jobs_done, 4);
        chk("gate_idle", idle, 1);
        chk("gate_we_idle", sram_we, 0);
        chk("gate_base_held", sram_wr_addr, 12'h001);
        acc_we = 1'b0; acc_wr_addr = '0;

        // FIFO full: job 1 occupies the engine, jobs 2..5 fill the FIFO,
        // job 6 waits until job 2 is popped.
        busy_len = 10; mon_en = 1'b1; done_ready = 1'b1;
        push(12'h010, 12'h020, 12'h030, 4'd1);
        push(12'h011, 12'h021, 12'h031, 4'd2);
        push(12'h012, 12'h022, 12'h032, 4'd3);
        push(12'h013, 12'h023, 12'h033, 4'd4);
        chk("fifo_ready_3", job_ready, 1);
        push(12'h014, 12'h024, 12'h034, 4'd5);
        chk("fifo_full", job_ready, 0);
        job_in_base = 12'h015; job_out_base = 12'h025; job_w_base = 12'h035;
        job_id = 4'd6; job_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("fifo_full_hold", job_ready, 0);
        end
        push(12'h015, 12'h025, 12'h035, 4'd6);
        for (int i = 0; i < 600 && done_q.size() < 6; i++) @(negedge clk);
        chk("fifo_done_count", done_q.size(), 6);
        for (int i = 0; i < done_q.size(); i++) chk("fifo_order", done_q[i], 32'(i + 1));
        @(negedge clk);
        mon_en = 1'b0; done_ready = 1'b0;
        chk("fifo_jobs", jobs_done, 10);
        chk("fifo_idle", idle, 1);

        // Reset in the middle of RUN with two jobs still queued.
        busy_len = 50;
        push(12'h300, 12'h400, 12'h500, 4'd10);
        push(12'h301, 12'h401, 12'h501, 4'd11);
        push(12'h302, 12'h402, 12'h502, 4'd12);
        repeat (4) @(negedge clk);
        chk("pre_rst_idle", idle, 0);
        acc_rd_addr = 12'h005; acc_we = 1'b1;
        reset_b = 1'b0; #1;
        chk("mid_rst_run", acc_run, 0);
        chk("mid_rst_valid", done_valid, 0);
        chk("mid_rst_id", done_id, 0);
        chk("mid_rst_err", done_err, 0);
        chk("mid_rst_cycles", done_cycles, 0);
        chk("mid_rst_jobs", jobs_done, 0);
        chk("mid_rst_ready", job_ready, 1);
        chk("mid_rst_idle", idle, 1);
        chk("mid_rst_we", sram_we, 0);
        chk("mid_rst_base", sram_rd_addr, 12'h005);
        @(negedge clk);
        reset_b = 1'b1; acc_we = 1'b0; acc_rd_addr = '0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", idle, 1);
            chk("post_rst_run", acc_run, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
